// File: rtl/game_pkg.sv
// Shared game constants: button bit positions, default screen geometry and the
// player-motion FSM state encoding.
package game_pkg;

  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_LEFT  = 0;

  localparam int unsigned POS_W_DEF = 10;
  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_COMMIT
  } motion_state_e;

endpackage

// File: rtl/player_motion_engine_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, the first one
// TICK_DIV cycles after reset is released.
module tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/player_motion_engine.sv
// Player movement engine: on each move tick, proposes a clamped step per axis,
// scans all rectangles one per cycle, and commits each axis only if it is clear.
module player_motion_engine
  import game_pkg::*;
#(
  parameter int unsigned N_OBJ    = 24,
  parameter int unsigned POS_W    = POS_W_DEF,
  parameter int unsigned H_RES    = H_RES_DEF,
  parameter int unsigned V_RES    = V_RES_DEF,
  parameter int unsigned PLAYER_W = 16,
  parameter int unsigned PLAYER_H = 16,
  parameter int unsigned STEP     = 2,
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned START_X  = 312,
  parameter int unsigned START_Y  = 232
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             btn,
  input  logic [N_OBJ-1:0]       obj_valid,
  input  logic [N_OBJ*POS_W-1:0] obj_x,
  input  logic [N_OBJ*POS_W-1:0] obj_y,
  input  logic [N_OBJ*POS_W-1:0] obj_w,
  input  logic [N_OBJ*POS_W-1:0] obj_ht,
  output logic [POS_W-1:0]       player_x,
  output logic [POS_W-1:0]       player_y,
  output logic [N_OBJ-1:0]       hit_vec,
  output logic [3:0]             blocked,
  output logic                   busy,
  output logic                   tick_miss
);

  localparam int unsigned       IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int unsigned       SW       = POS_W + 2;
  localparam logic [POS_W-1:0]  X_MAX    = POS_W'(H_RES - PLAYER_W);
  localparam logic [POS_W-1:0]  Y_MAX    = POS_W'(V_RES - PLAYER_H);
  localparam logic [POS_W-1:0]  PW       = POS_W'(PLAYER_W);
  localparam logic [POS_W-1:0]  PH       = POS_W'(PLAYER_H);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_OBJ - 1);
  localparam logic signed [SW-1:0] STEP_S = SW'(STEP);

  motion_state_e    state_q, state_d;
  logic [3:0]       btn_q, btn_d;
  logic [POS_W-1:0] px_q, px_d, py_q, py_d;
  logic [POS_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic             xhit_q, xhit_d, yhit_q, yhit_d;
  logic [N_OBJ-1:0] hit_acc_q, hit_acc_d, hit_vec_q, hit_vec_d;
  logic [3:0]       blocked_q, blocked_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             miss_q, miss_d;
  logic             tick;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Sums carry one extra bit so an edge near the top of the range cannot wrap.
  function automatic logic span_overlap(input logic [POS_W-1:0] a, a_len, b, b_len);
    return ({1'b0, a} < ({1'b0, b} + {1'b0, b_len})) &&
           ({1'b0, b} < ({1'b0, a} + {1'b0, a_len}));
  endfunction

  function automatic logic [POS_W-1:0] step_clamp(input logic [POS_W-1:0] pos,
                                                  input logic signed [SW-1:0] d,
                                                  input logic [POS_W-1:0] hi);
    logic signed [SW-1:0] s;
    s = $signed({2'b00, pos}) + d;
    if (s[SW-1])                          return '0;
    else if (s > $signed({2'b00, hi}))    return hi;
    else                                  return s[POS_W-1:0];
  endfunction

  logic xr, xl, yd, yu;
  logic signed [SW-1:0] dx, dy;

  assign xr = btn_q[BTN_RIGHT] & ~btn_q[BTN_LEFT];
  assign xl = btn_q[BTN_LEFT]  & ~btn_q[BTN_RIGHT];
  assign yd = btn_q[BTN_DOWN]  & ~btn_q[BTN_UP];
  assign yu = btn_q[BTN_UP]    & ~btn_q[BTN_DOWN];
  assign dx = xr ? STEP_S : (xl ? -STEP_S : '0);
  assign dy = yd ? STEP_S : (yu ? -STEP_S : '0);

  logic [31:0]      base;
  logic [POS_W-1:0] ox, oy, ow, oh;
  logic             obj_live, xtest, ytest;

  assign base     = 32'(idx_q) * POS_W;
  assign ox       = obj_x[base +: POS_W];
  assign oy       = obj_y[base +: POS_W];
  assign ow       = obj_w[base +: POS_W];
  assign oh       = obj_ht[base +: POS_W];
  assign obj_live = obj_valid[idx_q] && (ow != '0) && (oh != '0);
  // Each axis is tested with the other axis held at its committed position.
  assign xtest    = obj_live && (xr | xl) &&
                    span_overlap(cx_q, PW, ox, ow) && span_overlap(py_q, PH, oy, oh);
  assign ytest    = obj_live && (yd | yu) &&
                    span_overlap(px_q, PW, ox, ow) && span_overlap(cy_q, PH, oy, oh);

  always_comb begin
    state_d   = state_q;
    btn_d     = btn_q;
    px_d      = px_q;
    py_d      = py_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    xhit_d    = xhit_q;
    yhit_d    = yhit_q;
    hit_acc_d = hit_acc_q;
    hit_vec_d = hit_vec_q;
    blocked_d = blocked_q;
    idx_d     = idx_q;
    miss_d    = miss_q | (tick & (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          btn_d   = btn;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cx_d      = step_clamp(px_q, dx, X_MAX);
        cy_d      = step_clamp(py_q, dy, Y_MAX);
        xhit_d    = 1'b0;
        yhit_d    = 1'b0;
        hit_acc_d = '0;
        idx_d     = '0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        xhit_d           = xhit_q | xtest;
        yhit_d           = yhit_q | ytest;
        hit_acc_d[idx_q] = xtest | ytest;
        if (idx_q == IDX_LAST) state_d = ST_COMMIT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_COMMIT: begin
        if (!xhit_q) px_d = cx_q;
        if (!yhit_q) py_d = cy_q;
        hit_vec_d            = hit_acc_q;
        blocked_d[BTN_RIGHT] = xr & (xhit_q | (cx_q == px_q));
        blocked_d[BTN_LEFT]  = xl & (xhit_q | (cx_q == px_q));
        blocked_d[BTN_DOWN]  = yd & (yhit_q | (cy_q == py_q));
        blocked_d[BTN_UP]    = yu & (yhit_q | (cy_q == py_q));
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      btn_q     <= '0;
      px_q      <= POS_W'(START_X);
      py_q      <= POS_W'(START_Y);
      cx_q      <= '0;
      cy_q      <= '0;
      xhit_q    <= 1'b0;
      yhit_q    <= 1'b0;
      hit_acc_q <= '0;
      hit_vec_q <= '0;
      blocked_q <= '0;
      idx_q     <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      px_q      <= px_d;
      py_q      <= py_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      xhit_q    <= xhit_d;
      yhit_q    <= yhit_d;
      hit_acc_q <= hit_acc_d;
      hit_vec_q <= hit_vec_d;
      blocked_q <= blocked_d;
      idx_q     <= idx_d;
      miss_q    <= miss_d;
    end
  end

  assign player_x  = px_q;
  assign player_y  = py_q;
  assign hit_vec   = hit_vec_q;
  assign blocked   = blocked_q;
  assign busy      = (state_q != ST_IDLE);
  assign tick_miss = miss_q;

endmodule

// File: tb/tb_player_motion_engine.sv
// Bench for player_motion_engine: per-tick reference model of the movement rules,
// per-cycle output comparison, directed wall/clamp/reset cases and random play.
module tb_player_motion_engine;

  localparam int N   = 4;
  localparam int PW  = 10;
  localparam int DIV = 16;
  localparam int LAT = N + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rst2 = 1'b1;
  logic [3:0]      btn = '0;
  logic [N-1:0]    obj_valid = '0;
  logic [N*PW-1:0] obj_x = '0, obj_y = '0, obj_w = '0, obj_ht = '0;

  logic [PW-1:0]   player_x, player_y, p2_x, p2_y;
  logic [N-1:0]    hit_vec, hit2;
  logic [3:0]      blocked, blk2;
  logic            busy, tick_miss, busy2, miss2;

  player_motion_engine #(.N_OBJ(N), .POS_W(PW), .TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn(btn), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_ht(obj_ht),
    .player_x(player_x), .player_y(player_y), .hit_vec(hit_vec),
    .blocked(blocked), .busy(busy), .tick_miss(tick_miss)
  );

  player_motion_engine #(.N_OBJ(N), .POS_W(PW), .TICK_DIV(3)) dut_fast (
    .clk(clk), .rst(rst2), .btn(btn), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_ht(obj_ht),
    .player_x(p2_x), .player_y(p2_y), .hit_vec(hit2),
    .blocked(blk2), .busy(busy2), .tick_miss(miss2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the outcome of one tick from the movement rules.
  int m_x, m_y, m_hit, m_blk, p_x, p_y, p_hit, p_blk;
  bit m_busy;
  bit armed = 1'b0;
  int ecount = 0;

  task automatic model_eval(input logic [3:0] b, input int px, input int py,
                            output int nx, output int ny, output int hv, output int bl);
    int dx, dy, cx, cy, ox, oy, ow, oh;
    bit xh, yh, hx, hy;
    dx = 0; dy = 0;
    if (b[1] && !b[0]) dx = 2; else if (b[0] && !b[1]) dx = -2;
    if (b[2] && !b[3]) dy = 2; else if (b[3] && !b[2]) dy = -2;
    cx = px + dx; if (cx < 0) cx = 0; if (cx > 640 - 16) cx = 640 - 16;
    cy = py + dy; if (cy < 0) cy = 0; if (cy > 480 - 16) cy = 480 - 16;
    xh = 0; yh = 0; hv = 0;
    for (int i = 0; i < N; i++) begin
      ox = int'(obj_x[i*PW +: PW]);
      oy = int'(obj_y[i*PW +: PW]);
      ow = int'(obj_w[i*PW +: PW]);
      oh = int'(obj_ht[i*PW +: PW]);
      hx = 0; hy = 0;
      if (obj_valid[i] && ow > 0 && oh > 0) begin
        hx = (dx != 0) && cx < ox + ow && ox < cx + 16 && py < oy + oh && oy < py + 16;
        hy = (dy != 0) && px < ox + ow && ox < px + 16 && cy < oy + oh && oy < cy + 16;
      end
      if (hx) xh = 1;
      if (hy) yh = 1;
      if (hx || hy) hv = hv | (1 << i);
    end
    nx = xh ? px : cx;
    ny = yh ? py : cy;
    bl = 0;
    if (dx > 0 && (xh || cx == px)) bl = bl | 2;
    if (dx < 0 && (xh || cx == px)) bl = bl | 1;
    if (dy > 0 && (yh || cy == py)) bl = bl | 4;
    if (dy < 0 && (yh || cy == py)) bl = bl | 8;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ecount = 0;
      m_x = 312; m_y = 232; m_hit = 0; m_blk = 0; m_busy = 0;
    end else begin
      ecount++;
      if (ecount % DIV == 0) model_eval(btn, m_x, m_y, p_x, p_y, p_hit, p_blk);
      if (ecount >= DIV && ecount % DIV == LAT) begin
        m_x = p_x; m_y = p_y; m_hit = p_hit; m_blk = p_blk;
      end
      m_busy = (ecount >= DIV) && (ecount % DIV < LAT);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("player_x", int'(player_x), m_x);
      check("player_y", int'(player_y), m_y);
      check("hit_vec", int'(hit_vec), m_hit);
      check("blocked", int'(blocked), m_blk);
      check("busy", int'(busy), int'(m_busy));
      check("tick_miss", int'(tick_miss), 0);
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
  endtask

  // Wait for an idle point in the tick period; stimulus only changes there.
  task automatic sync_phase();
    do @(negedge clk); while (ecount % DIV != 8);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h, input bit v);
    obj_x[i*PW +: PW]  = PW'(x);
    obj_y[i*PW +: PW]  = PW'(y);
    obj_w[i*PW +: PW]  = PW'(w);
    obj_ht[i*PW +: PW] = PW'(h);
    obj_valid[i]       = v;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 1'b0);
  endtask

  int busy_cnt;
  int rx, ry;

  initial begin
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_x", int'(player_x), 312);
    check("reset_y", int'(player_y), 232);
    check("reset_busy", int'(busy), 0);
    check("reset_hit", int'(hit_vec), 0);
    check("reset_blocked", int'(blocked), 0);
    check("fast_miss_reset", int'(miss2), 0);

    // Open field, moving right; busy spans LAT cycles of each period.
    sync_phase(); btn = 4'b0010;
    wait_ticks(2);
    busy_cnt = 0;
    repeat (DIV) begin @(negedge clk); busy_cnt += int'(busy); end
    check("open_x", int'(player_x), 318);
    check("open_busy_cycles", busy_cnt, 6);
    check("open_hit", int'(hit_vec), 0);

    // Wall on the right.
    do_reset(); sync_phase();
    set_obj(0, 330, 232, 20, 16, 1'b1);
    btn = 4'b0010;
    wait_ticks(3);
    check("wall_x", int'(player_x), 314);
    check("wall_blocked", int'(blocked), 2);
    check("wall_hit", int'(hit_vec), 1);

    // Diagonal into the wall slides vertically.
    btn = 4'b0110;
    wait_ticks(2);
    check("slide_x", int'(player_x), 314);
    check("slide_y", int'(player_y), 236);
    check("slide_blocked", int'(blocked), 2);

    // Reset landing in the middle of a scan.
    sync_phase();
    do @(negedge clk); while (ecount % DIV != 2);
    check("midscan_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midscan_x", int'(player_x), 312);
    check("midscan_y", int'(player_y), 232);
    check("midscan_busy", int'(busy), 0);
    check("midscan_hit", int'(hit_vec), 0);
    check("midscan_blocked", int'(blocked), 0);
    rst = 1'b0;

    // Drive into the top-left corner and push against it.
    do_reset(); sync_phase();
    clear_objs();
    btn = 4'b1001;
    wait_ticks(160);
    check("corner_x", int'(player_x), 0);
    check("corner_y", int'(player_y), 0);
    check("corner_blocked", int'(blocked), 9);

    // Opposing X buttons plus touching objects.
    set_obj(0, 16, 0, 10, 10, 1'b1);
    btn = 4'b0111;
    wait_ticks(2);
    check("cancel_x", int'(player_x), 0);
    check("cancel_y", int'(player_y), 4);
    check("cancel_hit", int'(hit_vec), 0);
    check("cancel_blocked", int'(blocked), 0);
    set_obj(1, 0, 22, 10, 10, 1'b1);
    btn = 4'b0100;
    wait_ticks(1);
    check("touch_y", int'(player_y), 6);
    check("touch_hit", int'(hit_vec), 0);
    wait_ticks(1);
    check("contact_y", int'(player_y), 6);
    check("contact_hit", int'(hit_vec), 2);
    check("contact_blocked", int'(blocked), 4);

    // Random play around the player.
    do_reset();
    for (int t = 0; t < 150; t++) begin
      sync_phase();
      if (t % 10 == 0) begin
        for (int i = 0; i < N; i++) begin
          rx = m_x + int'($urandom_range(0, 80)) - 40;
          ry = m_y + int'($urandom_range(0, 80)) - 40;
          if (rx < 0) rx = 0; if (rx > 620) rx = 620;
          if (ry < 0) ry = 0; if (ry > 460) ry = 460;
          set_obj(i, rx, ry, int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                  $urandom_range(0, 3) != 0);
        end
      end
      btn = 4'($urandom_range(0, 15));
    end
    sync_phase();

    check("fast_miss_set", int'(miss2), 1);
    repeat (20) @(negedge clk);
    check("fast_miss_sticky", int'(miss2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
